// File: rtl/tx_iq_framer_pkg.sv
// Shared constants, state encoding and word builder for the TX IQ framer.
// The I/Q field positions are the same ones rx_framer uses.
package tx_iq_framer_pkg;

  localparam logic [1:0]  SYNC_I    = 2'b10;
  localparam logic [1:0]  SYNC_Q    = 2'b01;
  localparam logic [31:0] ZERO_WORD = 32'h8000_4000;

  localparam int I_MSB = 28;
  localparam int I_LSB = 16;
  localparam int Q_MSB = 12;
  localparam int Q_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  function automatic logic [31:0] build_word(input logic [12:0] i_val, input logic [12:0] q_val);
    return {SYNC_I, i_val, 1'b0, SYNC_Q, q_val, 1'b0};
  endfunction

endpackage

// File: rtl/tx_iq_framer_shifter.sv
// 32-bit modem word shifter (MSB pair first) plus the 0..15 word phase counter.
module tx_iq_shifter (
  input  logic        i_ddr_clk,
  input  logic        i_rst_b,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        advance,
  output logic [1:0]  pair,
  output logic [3:0]  phase
);

  logic [31:0] shift_reg;

  // Outside RUN the shifter is cleared and the phase parked at 0.
  always_ff @(posedge i_ddr_clk) begin
    if (!i_rst_b) begin
      shift_reg <= '0;
      phase     <= '0;
    end else if (load) begin
      shift_reg <= load_word;
      phase     <= 4'd0;
    end else if (advance) begin
      shift_reg <= {shift_reg[29:0], 2'b00};
      phase     <= phase + 4'd1;
    end else begin
      shift_reg <= '0;
      phase     <= 4'd0;
    end
  end

  assign pair = shift_reg[31:30];

endmodule

// File: rtl/tx_iq_framer.sv
// Streams FIFO I/Q samples to the LVDS modem as 32-bit framed words, two bits
// per DDR clock, substituting a zero or repeated word when the FIFO runs dry.
module tx_iq_framer
  import tx_iq_framer_pkg::*;
#(
  parameter bit UNDERRUN_REPEAT = 1'b0,
  parameter int CNT_W           = 16
) (
  input  logic             i_ddr_clk,
  input  logic             i_rst_b,
  input  logic             i_enable,
  output logic             o_fifo_pull,
  input  logic [31:0]      i_fifo_pulled_data,
  input  logic             i_fifo_empty,
  output logic [1:0]       o_ddr_data,
  output logic             o_word_strobe,
  output logic             o_underrun,
  output logic [CNT_W-1:0] o_underrun_count,
  output logic             o_active
);

  state_t           state, next_state;
  logic [3:0]       phase;
  logic [1:0]       shift_pair;
  logic             pull, load, advance, underrun_load;
  logic [31:0]      load_word, fresh_word, staging, last_word;
  logic             prime_pulled, prime_captured, run_pulled, keep_run;
  logic             word_strobe, underrun_pulse;
  logic [CNT_W-1:0] underrun_count;
  logic             unused_fifo_bits;

  assign fresh_word       = build_word(i_fifo_pulled_data[I_MSB:I_LSB], i_fifo_pulled_data[Q_MSB:Q_LSB]);
  assign unused_fifo_bits = ^{i_fifo_pulled_data[31:29], i_fifo_pulled_data[15:13]};

  tx_iq_shifter u_shifter (
    .i_ddr_clk (i_ddr_clk),
    .i_rst_b   (i_rst_b),
    .load      (load),
    .load_word (load_word),
    .advance   (advance),
    .pair      (shift_pair),
    .phase     (phase)
  );

  // PRIME runs pull / capture / load over three cycles so the first RUN pull
  // lands exactly 16 cycles after the priming pull.
  always_comb begin
    next_state    = state;
    pull          = 1'b0;
    load          = 1'b0;
    advance       = 1'b0;
    underrun_load = 1'b0;
    load_word     = staging;
    case (state)
      ST_IDLE: begin
        if (i_enable) next_state = ST_PRIME;
      end
      ST_PRIME: begin
        if (prime_captured) begin
          load       = 1'b1;
          next_state = ST_RUN;
        end else if (!prime_pulled && !i_fifo_empty) begin
          pull = 1'b1;
        end
      end
      ST_RUN: begin
        advance = 1'b1;
        if (phase == 4'd13) pull = i_enable && !i_fifo_empty;
        if (phase == 4'd15) begin
          if (!keep_run) begin
            next_state = ST_IDLE;
          end else begin
            load = 1'b1;
            if (!run_pulled) begin
              underrun_load = 1'b1;
              load_word     = UNDERRUN_REPEAT ? last_word : ZERO_WORD;
            end
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Whether the stream continues is decided by i_enable at phase 13, so an
  // enable drop after the last fetch point never produces a counted underrun.
  always_ff @(posedge i_ddr_clk) begin
    if (!i_rst_b) begin
      state          <= ST_IDLE;
      prime_pulled   <= 1'b0;
      prime_captured <= 1'b0;
      run_pulled     <= 1'b0;
      keep_run       <= 1'b0;
      staging        <= '0;
      last_word      <= '0;
      word_strobe    <= 1'b0;
      underrun_pulse <= 1'b0;
      underrun_count <= '0;
    end else begin
      state          <= next_state;
      word_strobe    <= load;
      underrun_pulse <= underrun_load;
      prime_pulled   <= (state == ST_PRIME) && pull;
      prime_captured <= (state == ST_PRIME) && prime_pulled;
      if (state == ST_RUN && phase == 4'd13) begin
        run_pulled <= pull;
        keep_run   <= i_enable;
      end
      if (prime_pulled || (state == ST_RUN && phase == 4'd14 && run_pulled))
        staging <= fresh_word;
      if (load) last_word <= load_word;
      if (state == ST_IDLE && next_state == ST_PRIME)
        underrun_count <= '0;
      else if (underrun_load && underrun_count != {CNT_W{1'b1}})
        underrun_count <= underrun_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_fifo_pull      = pull && i_rst_b;
  assign o_ddr_data       = (state == ST_RUN) ? shift_pair : 2'b00;
  assign o_word_strobe    = word_strobe;
  assign o_underrun       = underrun_pulse;
  assign o_underrun_count = underrun_count;
  assign o_active         = (state == ST_PRIME) || (state == ST_RUN);

endmodule

// File: doc/tx_iq_framer.md
TX_IQ_FRAMER -- requirements
Module: tx_iq_framer

Interface
REQ-001 Parameter UNDERRUN_REPEAT, default 0; 0 = send the zero-sample word on underrun, 1 = repeat the last word sent.
REQ-002 Parameter CNT_W, default 16; width of the underrun counter.
REQ-003 i_ddr_clk  in  1  LVDS TX DDR clock, the only clock; all logic is on its rising edge.
REQ-004 i_rst_b  in  1  reset, synchronous, active-low.
REQ-005 i_enable  in  1  request to stream samples to the modem.
REQ-006 o_fifo_pull  out  1  one-cycle read strobe to the TX afifo.
REQ-007 i_fifo_pulled_data  in  32  FIFO word {3'b000, I[12:0], 3'b000, Q[12:0]}, valid the cycle after o_fifo_pull.
REQ-008 i_fifo_empty  in  1  TX afifo empty flag.
REQ-009 o_ddr_data  out  2  bit pair for the DDR SB_IO; [1] = D_OUT_0 (earlier bit), [0] = D_OUT_1.
REQ-010 o_word_strobe  out  1  pulses for one cycle when a new 32-bit word is loaded into the shifter.
REQ-011 o_underrun  out  1  pulses for one cycle on each word loaded without fresh FIFO data.
REQ-012 o_underrun_count  out  CNT_W  saturating count of underrun words.
REQ-013 o_active  out  1  high in the PRIME and RUN states.

Function
REQ-014 Modem word: {2'b10, I[12:0], 1'b0, 2'b01, Q[12:0], 1'b0}; I = fifo[28:16], Q = fifo[12:0], and fifo[31:29] and fifo[15:13] are ignored.
REQ-015 Shift MSB first, two bits per cycle: o_ddr_data = shifter[31:30], then a left shift by 2; one word takes 16 cycles.
REQ-016 A 4-bit phase counter runs 0..15 and wraps in RUN; the word loads on the phase 15->0 transition.
REQ-017 States: IDLE, PRIME, RUN.
REQ-018 IDLE: o_ddr_data = 2'b00, no pulls, phase held at 0; go to PRIME when i_enable=1.
REQ-019 PRIME: when i_fifo_empty=0, assert o_fifo_pull for one cycle and capture the data on the next cycle. Then load the shifter, pulse o_word_strobe, and go to RUN with phase=0. PRIME waits indefinitely while the FIFO is empty, driving 2'b00.
REQ-020 RUN fetch: at phase 13, o_fifo_pull = !i_fifo_empty; at phase 14, capture i_fifo_pulled_data into the staging register if pulled; at phase 15->0, load the staging word.
REQ-021 Underrun: if no pull occurred at phase 13, load the zero word 0x80004000 (UNDERRUN_REPEAT=0) or the previous word (UNDERRUN_REPEAT=1).
REQ-022 On each underrun load, pulse o_underrun together with o_word_strobe, and increment o_underrun_count, saturating at all-ones.
REQ-023 i_enable deassert in RUN: the word in flight completes. No pull is issued at phase 13 when i_enable=0. At phase 15->0 go to IDLE with no load and no strobe.
REQ-024 i_enable reasserted before phase 13 continues streaming with no gap.
REQ-025 An underrun occurring on the same cycle as an enable drop is not counted.
REQ-026 o_fifo_pull is never asserted while i_fifo_empty=1, and at most once per 16 cycles.
REQ-027 o_underrun_count clears on the IDLE->PRIME transition.

Reset
REQ-028 While i_rst_b=0 at a clock edge, the next state is:
- state IDLE, phase 0;
- shifter, staging register and last-word register all zero;
- o_ddr_data=2'b00 and o_fifo_pull, o_word_strobe, o_underrun, o_active all 0;
- o_underrun_count=0.
REQ-029 Reset mid-word truncates the word immediately; no pending pull is completed.
REQ-030 In the first cycle after reset release, outputs equal IDLE values.

Structure
REQ-031 The shared package holds:
- SYNC_I=2'b10 and SYNC_Q=2'b01;
- ZERO_WORD=32'h80004000;
- the state encoding;
- field positions I_MSB=28, I_LSB=16, Q_MSB=12, Q_LSB=0.
rx_framer uses the same field positions.
REQ-032 One sub-module, tx_iq_shifter, holds the 32-bit load/shift register and the phase counter. Control, fetch and underrun logic remain in tx_iq_framer.

Verification
REQ-033 FIFO word 0x0ABC1DEF, enable=1 -> o_word_strobe, then 16 pairs serialising 0x95787BDE MSB first (first pair 2'b10).
REQ-034 FIFO empty after one word, UNDERRUN_REPEAT=0 -> next word 0x80004000, o_underrun pulse, count=1. UNDERRUN_REPEAT=1 -> the previous word repeats.
REQ-035 Enable dropped at phase 5 -> remaining 10 pairs sent, no pull at phase 13, IDLE with 2'b00 from the next cycle.
REQ-036 i_rst_b=0 at phase 8 -> o_ddr_data=2'b00 and IDLE on the next edge, no o_fifo_pull.
REQ-037 CNT_W=4, 20 consecutive underruns -> count saturates at 15 and o_underrun still pulses each word.
REQ-038 Continuous 1000-word stream -> exactly one pull per 16 cycles at phase 13, zero underruns, and the output words equal the remapped input words in order.
